// File: rtl/adc_scan_bcd.sv
// Round-robin ADC scanner: box-car averages each channel, scales to tenths of a degree,
// converts to 4-digit BCD with a serial double-dabble and keeps per-channel hysteretic alarms.
module adc_scan_bcd #(
   parameter int N_CH         = 4,
   parameter int AVG_LOG2     = 3,
   parameter int ADC_W        = 16,
   parameter int SCALE_SHIFT  = 3,
   parameter int ALARM_TENTHS = 300,
   parameter int HYST_TENTHS  = 20,
   parameter int TIMEOUT      = 1000000,
   localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   output logic              smp_req,
   output logic [CH_W-1:0]   smp_ch,
   input  logic              smp_valid,
   input  logic [ADC_W-1:0]  smp_data,
   output logic              res_valid,
   output logic [CH_W-1:0]   res_ch,
   output logic [15:0]       res_bcd,
   output logic              res_neg,
   output logic              res_ovf,
   output logic              res_err,
   output logic [N_CH-1:0]   alarm
);

   localparam int ACC_W = ADC_W + AVG_LOG2;
   localparam int CNT_W = AVG_LOG2 + 1;
   localparam int TO_W  = $clog2(TIMEOUT + 1);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);
   localparam logic [13:0]      SET_T    = 14'(ALARM_TENTHS);
   localparam logic [13:0]      CLR_T    = 14'(ALARM_TENTHS - HYST_TENTHS);

   typedef enum logic [2:0] {
      ST_IDLE, ST_REQ, ST_WAIT, ST_ACC, ST_SCALE, ST_BCD, ST_OUT
   } state_t;

   state_t                   state_q, state_d;
   logic [CH_W-1:0]          ch_q, ch_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [TO_W-1:0]          tcnt_q, tcnt_d;
   logic signed [ADC_W-1:0]  sample_q, sample_d;
   logic [13:0]              value_q, value_d;
   logic                     neg_q, neg_d;
   logic                     ovf_q, ovf_d;
   logic [13:0]              bin_q, bin_d;
   logic [15:0]              bcd_q, bcd_d;
   logic [3:0]               bit_q, bit_d;
   logic                     res_valid_q, res_valid_d;
   logic [CH_W-1:0]          res_ch_q, res_ch_d;
   logic [15:0]              res_bcd_q, res_bcd_d;
   logic                     res_neg_q, res_neg_d;
   logic                     res_ovf_q, res_ovf_d;
   logic                     res_err_q, res_err_d;
   logic [N_CH-1:0]          alarm_q, alarm_d;

   logic signed [ACC_W-1:0]  scale_avg;
   logic signed [ACC_W-1:0]  scale_t;
   logic [15:0]              dd_adj;

   assign scale_avg = acc_q >>> AVG_LOG2;
   assign scale_t   = scale_avg >>> SCALE_SHIFT;

   // Add-3 correction on every BCD digit that is 5 or more before the next shift.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_dd_nib
         assign dd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                              : bcd_q[4*gi +: 4];
      end
   endgenerate

   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      tcnt_d      = tcnt_q;
      sample_d    = sample_q;
      value_d     = value_q;
      neg_d       = neg_q;
      ovf_d       = ovf_q;
      bin_d       = bin_q;
      bcd_d       = bcd_q;
      bit_d       = bit_q;
      res_valid_d = 1'b0;
      res_ch_d    = res_ch_q;
      res_bcd_d   = res_bcd_q;
      res_neg_d   = res_neg_q;
      res_ovf_d   = res_ovf_q;
      res_err_d   = res_err_q;
      alarm_d     = alarm_q;

      case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_REQ;
         end
         ST_REQ: begin
            tcnt_d  = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // A valid arriving on the expiry cycle still wins over the timeout.
            if (smp_valid) begin
               sample_d = smp_data;
               state_d  = ST_ACC;
            end else begin
               tcnt_d = tcnt_q + TO_W'(1);
               if (tcnt_d == TO_LAST) begin
                  state_d     = ST_OUT;
                  res_valid_d = 1'b1;
                  res_ch_d    = ch_q;
                  res_bcd_d   = '0;
                  res_neg_d   = 1'b0;
                  res_ovf_d   = 1'b0;
                  res_err_d   = 1'b1;
               end
            end
         end
         ST_ACC: begin
            acc_d = acc_q + ACC_W'(sample_q);
            cnt_d = cnt_q + CNT_W'(1);
            state_d = (cnt_q == CNT_LAST) ? ST_SCALE : ST_REQ;
         end
         ST_SCALE: begin
            neg_d = 1'b0;
            ovf_d = 1'b0;
            if (scale_t[ACC_W-1]) begin
               value_d = '0;
               neg_d   = 1'b1;
            end else if (scale_t > $signed(ACC_W'(9999))) begin
               value_d = 14'd9999;
               ovf_d   = 1'b1;
            end else begin
               value_d = scale_t[13:0];
            end
            bin_d   = value_d;
            bcd_d   = '0;
            bit_d   = '0;
            state_d = ST_BCD;
         end
         ST_BCD: begin
            {bcd_d, bin_d} = {dd_adj, bin_q} << 1;
            bit_d = bit_q + 4'd1;
            if (bit_q == 4'd13) begin
               state_d     = ST_OUT;
               res_valid_d = 1'b1;
               res_ch_d    = ch_q;
               res_bcd_d   = bcd_d;
               res_neg_d   = neg_q;
               res_ovf_d   = ovf_q;
               res_err_d   = 1'b0;
               if (value_q >= SET_T)
                  alarm_d[ch_q] = 1'b1;
               else if (value_q < CLR_T)
                  alarm_d[ch_q] = 1'b0;
            end
         end
         ST_OUT: begin
            acc_d   = '0;
            cnt_d   = '0;
            ch_d    = (ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1);
            state_d = enable ? ST_REQ : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ch_q        <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         tcnt_q      <= '0;
         sample_q    <= '0;
         value_q     <= '0;
         neg_q       <= 1'b0;
         ovf_q       <= 1'b0;
         bin_q       <= '0;
         bcd_q       <= '0;
         bit_q       <= '0;
         res_valid_q <= 1'b0;
         res_ch_q    <= '0;
         res_bcd_q   <= '0;
         res_neg_q   <= 1'b0;
         res_ovf_q   <= 1'b0;
         res_err_q   <= 1'b0;
         alarm_q     <= '0;
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         tcnt_q      <= tcnt_d;
         sample_q    <= sample_d;
         value_q     <= value_d;
         neg_q       <= neg_d;
         ovf_q       <= ovf_d;
         bin_q       <= bin_d;
         bcd_q       <= bcd_d;
         bit_q       <= bit_d;
         res_valid_q <= res_valid_d;
         res_ch_q    <= res_ch_d;
         res_bcd_q   <= res_bcd_d;
         res_neg_q   <= res_neg_d;
         res_ovf_q   <= res_ovf_d;
         res_err_q   <= res_err_d;
         alarm_q     <= alarm_d;
      end
   end

   assign smp_req   = (state_q == ST_REQ);
   assign smp_ch    = ch_q;
   assign res_valid = res_valid_q;
   assign res_ch    = res_ch_q;
   assign res_bcd   = res_bcd_q;
   assign res_neg   = res_neg_q;
   assign res_ovf   = res_ovf_q;
   assign res_err   = res_err_q;
   assign alarm     = alarm_q;

endmodule

// File: tb/tb_adc_scan_bcd.sv
// Directed bench for adc_scan_bcd: a 4-channel instance with a short timeout and a
// single-channel unscaled instance for the BCD, saturation and negative-clamp paths.
`timescale 1ns/1ps
module tb_adc_scan_bcd;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        enable;
   logic        smp_req;
   logic [1:0]  smp_ch;
   logic        smp_valid;
   logic [15:0] smp_data;
   logic        res_valid;
   logic [1:0]  res_ch;
   logic [15:0] res_bcd;
   logic        res_neg, res_ovf, res_err;
   logic [3:0]  alarm;

   logic        b_enable;
   logic        b_smp_req;
   logic [0:0]  b_smp_ch;
   logic        b_smp_valid;
   logic [15:0] b_smp_data;
   logic        b_res_valid;
   logic [0:0]  b_res_ch;
   logic [15:0] b_res_bcd;
   logic        b_res_neg, b_res_ovf, b_res_err;
   logic [0:0]  b_alarm;

   int n_checks = 0;
   int n_errors = 0;

   adc_scan_bcd #(
      .N_CH(4), .AVG_LOG2(3), .ADC_W(16), .SCALE_SHIFT(3),
      .ALARM_TENTHS(300), .HYST_TENTHS(20), .TIMEOUT(50)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .smp_req(smp_req), .smp_ch(smp_ch), .smp_valid(smp_valid), .smp_data(smp_data),
      .res_valid(res_valid), .res_ch(res_ch), .res_bcd(res_bcd),
      .res_neg(res_neg), .res_ovf(res_ovf), .res_err(res_err), .alarm(alarm)
   );

   adc_scan_bcd #(
      .N_CH(1), .AVG_LOG2(0), .ADC_W(16), .SCALE_SHIFT(0),
      .ALARM_TENTHS(300), .HYST_TENTHS(20), .TIMEOUT(50)
   ) dut_b (
      .clk(clk), .rst(rst), .enable(b_enable),
      .smp_req(b_smp_req), .smp_ch(b_smp_ch), .smp_valid(b_smp_valid), .smp_data(b_smp_data),
      .res_valid(b_res_valid), .res_ch(b_res_ch), .res_bcd(b_res_bcd),
      .res_neg(b_res_neg), .res_ovf(b_res_ovf), .res_err(b_res_err), .alarm(b_alarm)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic sel_req(input int which);
      return (which == 0) ? smp_req : b_smp_req;
   endfunction

   function automatic logic sel_res_valid(input int which);
      return (which == 0) ? res_valid : b_res_valid;
   endfunction

   // Waits (bounded) for a request, then answers it with a one-cycle valid in WAIT.
   // Returns at the first falling edge after the edge that samples the valid.
   task automatic send(input int which, input logic [15:0] data, output int ch);
      int n;
      n = 0;
      while (n < 200 && sel_req(which) !== 1'b1) begin
         @(negedge clk);
         n++;
      end
      check("req_seen", 32'(sel_req(which)), 32'd1);
      ch = (which == 0) ? int'(smp_ch) : int'(b_smp_ch);
      @(negedge clk);
      if (which == 0) begin smp_valid = 1'b1; smp_data = data; end
      else begin b_smp_valid = 1'b1; b_smp_data = data; end
      @(negedge clk);
      smp_valid   = 1'b0;
      b_smp_valid = 1'b0;
   endtask

   // lat = index of the clock edge (counted from the final valid's edge) that samples res_valid.
   task automatic wait_res(input int which, output int lat);
      lat = 1;
      while (lat < 300 && sel_res_valid(which) !== 1'b1) begin
         @(negedge clk);
         lat++;
      end
      if (which == 0)
         $display("result dut=a ch=%0d bcd=%h neg=%b ovf=%b err=%b alarm=%b lat=%0d",
                  res_ch, res_bcd, res_neg, res_ovf, res_err, alarm, lat);
      else
         $display("result dut=b ch=%0d bcd=%h neg=%b ovf=%b err=%b alarm=%b lat=%0d",
                  b_res_ch, b_res_bcd, b_res_neg, b_res_ovf, b_res_err, b_alarm, lat);
   endtask

   task automatic run_chan(input logic [15:0] d_even, input logic [15:0] d_odd,
                           input int exp_ch, input string tag);
      int ch;
      int lat;
      for (int i = 0; i < 8; i++) begin
         send(0, (i % 2 == 0) ? d_even : d_odd, ch);
         if (i == 0) check({tag, "_smp_ch"}, 32'(ch), 32'(exp_ch));
      end
      wait_res(0, lat);
      check({tag, "_lat"}, 32'(lat), 32'd17);
      check({tag, "_res_ch"}, 32'(res_ch), 32'(exp_ch));
   endtask

   initial begin
      int ch;
      int lat;
      int cnt;
      rst = 1'b1; enable = 1'b0; smp_valid = 1'b0; smp_data = '0;
      b_enable = 1'b0; b_smp_valid = 1'b0; b_smp_data = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_smp_req", 32'(smp_req), 32'd0);
      check("rst_smp_ch", 32'(smp_ch), 32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_bcd", 32'(res_bcd), 32'd0);
      check("rst_flags", 32'({res_neg, res_ovf, res_err}), 32'd0);
      check("rst_alarm", 32'(alarm), 32'd0);

      // Unscaled single-channel instance: plain BCD, saturation, negative clamp.
      b_enable = 1'b1; send(1, 16'd1234, ch); b_enable = 1'b0;
      wait_res(1, lat);
      check("b_1234_lat", 32'(lat), 32'd17);
      check("b_1234_bcd", 32'(b_res_bcd), 32'h1234);
      check("b_1234_flags", 32'({b_res_neg, b_res_ovf, b_res_err}), 32'd0);
      check("b_1234_alarm", 32'(b_alarm), 32'd1);
      b_enable = 1'b1; send(1, 16'd32767, ch); b_enable = 1'b0;
      wait_res(1, lat);
      check("b_ovf_bcd", 32'(b_res_bcd), 32'h9999);
      check("b_ovf_flags", 32'({b_res_neg, b_res_ovf, b_res_err}), 32'b010);
      b_enable = 1'b1; send(1, 16'hFFFF, ch); b_enable = 1'b0;
      wait_res(1, lat);
      check("b_neg_bcd", 32'(b_res_bcd), 32'h0000);
      check("b_neg_flags", 32'({b_res_neg, b_res_ovf, b_res_err}), 32'b100);
      check("b_neg_alarm_clr", 32'(b_alarm), 32'd0);

      // Round 1 on the 4-channel instance.
      enable = 1'b1;
      run_chan(16'd2000, 16'd2000, 0, "r1c0");
      check("r1c0_bcd", 32'(res_bcd), 32'h0250);
      check("r1c0_flags", 32'({res_neg, res_ovf, res_err}), 32'd0);
      check("r1c0_alarm", 32'(alarm), 32'b0000);
      @(negedge clk);
      check("r1c0_pulse", 32'(res_valid), 32'd0);
      check("r1c0_hold", 32'(res_bcd), 32'h0250);

      run_chan(16'd2400, 16'd2408, 1, "r1c1");
      check("r1c1_bcd", 32'(res_bcd), 32'h0300);
      check("r1c1_alarm", 32'(alarm), 32'b0010);

      run_chan(16'hFCE0, 16'hFCE0, 2, "r1c2");
      check("r1c2_bcd", 32'(res_bcd), 32'h0000);
      check("r1c2_flags", 32'({res_neg, res_ovf, res_err}), 32'b100);
      check("r1c2_alarm", 32'(alarm), 32'b0010);

      // Channel 3: three samples, then the fourth request goes unanswered.
      for (int i = 0; i < 3; i++) begin
         send(0, 16'd100, ch);
         if (i == 0) check("r1c3_smp_ch", 32'(ch), 32'd3);
      end
      cnt = 0;
      while (cnt < 200 && smp_req !== 1'b1) begin
         @(negedge clk);
         cnt++;
      end
      check("r1c3_req4", 32'(smp_req), 32'd1);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (lat < 300 && res_valid !== 1'b1);
      $display("result dut=a ch=%0d bcd=%h neg=%b ovf=%b err=%b alarm=%b lat=%0d",
               res_ch, res_bcd, res_neg, res_ovf, res_err, alarm, lat);
      check("r1c3_to_lat", 32'(lat), 32'd50);
      check("r1c3_res_ch", 32'(res_ch), 32'd3);
      check("r1c3_bcd", 32'(res_bcd), 32'h0000);
      check("r1c3_flags", 32'({res_neg, res_ovf, res_err}), 32'b001);
      check("r1c3_alarm", 32'(alarm), 32'b0010);

      // Round 2: enable dropped during ch0's 4th sample.
      for (int i = 0; i < 8; i++) begin
         send(0, 16'd2000, ch);
         if (i == 0) check("r2c0_wrap_ch", 32'(ch), 32'd0);
         if (i == 3) enable = 1'b0;
      end
      wait_res(0, lat);
      check("r2c0_res_ch", 32'(res_ch), 32'd0);
      check("r2c0_bcd", 32'(res_bcd), 32'h0250);
      cnt = 0;
      repeat (30) begin
         @(negedge clk);
         if (smp_req) cnt++;
      end
      check("r2_idle_no_req", 32'(cnt), 32'd0);
      enable = 1'b1;
      run_chan(16'd2300, 16'd2300, 1, "r2c1");
      check("r2c1_bcd", 32'(res_bcd), 32'h0287);
      check("r2c1_alarm_held", 32'(alarm), 32'b0010);
      run_chan(16'd0, 16'd0, 2, "r2c2");
      check("r2c2_bcd", 32'(res_bcd), 32'h0000);
      check("r2c2_flags", 32'({res_neg, res_ovf, res_err}), 32'd0);
      run_chan(16'd3000, 16'd3000, 3, "r2c3");
      check("r2c3_bcd", 32'(res_bcd), 32'h0375);
      check("r2c3_alarm", 32'(alarm), 32'b1010);

      // Round 3: ch1 falls below the clear threshold.
      run_chan(16'd2000, 16'd2000, 0, "r3c0");
      check("r3c0_alarm", 32'(alarm), 32'b1010);
      run_chan(16'd2200, 16'd2200, 1, "r3c1");
      check("r3c1_bcd", 32'(res_bcd), 32'h0275);
      check("r3c1_alarm_clr", 32'(alarm), 32'b1000);

      // Reset while ch2 is in its BCD phase.
      for (int i = 0; i < 8; i++) send(0, 16'd1000, ch);
      repeat (3) @(negedge clk);
      rst = 1'b1; enable = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_smp_req", 32'(smp_req), 32'd0);
      check("mid_rst_smp_ch", 32'(smp_ch), 32'd0);
      check("mid_rst_res_valid", 32'(res_valid), 32'd0);
      check("mid_rst_res_bcd", 32'(res_bcd), 32'd0);
      check("mid_rst_res_ch", 32'(res_ch), 32'd0);
      check("mid_rst_flags", 32'({res_neg, res_ovf, res_err}), 32'd0);
      check("mid_rst_alarm", 32'(alarm), 32'd0);
      @(negedge clk);
      smp_valid = 1'b1; smp_data = 16'd2000;
      @(negedge clk);
      smp_valid = 1'b0;
      cnt = 0;
      lat = 0;
      repeat (40) begin
         @(negedge clk);
         if (res_valid) cnt++;
         if (smp_req) lat++;
      end
      check("stray_no_result", 32'(cnt), 32'd0);
      check("stray_no_req", 32'(lat), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/adc_scan_bcd.md
Name: adc_scan_bcd

Overview:
Multi-channel successor to the single-channel ADC → conversion → BCD chain. It sequences reads over N_CH ADC inputs through a request/valid handshake to the I2C reader, and box-car averages 2^AVG_LOG2 samples per channel. It scales the average to tenths of °C and converts it to 4-digit BCD with a sequential double-dabble. Per-channel hysteretic alarm flags drive the LED block, and the BCD result stream drives the LCD driver.

Parameters:
N_CH, 4, number of channels scanned round-robin (1..16)
AVG_LOG2, 3, log2 of samples averaged per result (0..6)
ADC_W, 16, signed ADC sample width
SCALE_SHIFT, 3, arithmetic right shift from averaged code to tenths °C (ADS1115 ±4.096 V + LM35 = 3)
ALARM_TENTHS, 300, alarm set threshold in tenths °C
HYST_TENTHS, 20, alarm clear hysteresis in tenths °C
TIMEOUT, 1000000, clk cycles to wait for smp_valid before flagging error

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
enable  in  1  run scanning while high
smp_req  out  1  one-cycle pulse requesting a conversion on smp_ch
smp_ch  out  clog2(N_CH) max 1  channel being sampled
smp_valid  in  1  one-cycle pulse, smp_data valid
smp_data  in  ADC_W  signed two's-complement sample
res_valid  out  1  one-cycle pulse, result fields valid
res_ch  out  clog2(N_CH) max 1  channel of result
res_bcd  out  16  {CENT,DECE,UNID,DECI} nibbles, xxx.x °C
res_neg  out  1  average was negative, value clamped to 0
res_ovf  out  1  value saturated to 999.9
res_err  out  1  sample timeout on this channel
alarm  out  N_CH  per-channel hysteretic over-temperature flags

Behaviour:
- Reset: every output 0, state IDLE, channel 0, accumulator/sample counter/timeout counter 0, alarm 0. Reset mid-operation aborts immediately; a late smp_valid after reset is ignored.
- States:
  - IDLE: go to REQ when enable=1.
  - REQ: smp_req=1 for exactly 1 cycle, go to WAIT, clear timeout counter.
  - WAIT: smp_valid=1 → sign-extend and add smp_data to the (ADC_W+AVG_LOG2)-bit accumulator, increment sample count. If count reaches 2^AVG_LOG2, go to SCALE; else go to REQ. If the timeout counter reaches TIMEOUT-1 without smp_valid, go to OUT with err set.
  - SCALE (1 cycle): avg = acc >>> AVG_LOG2; t = avg >>> SCALE_SHIFT (both arithmetic, truncate toward −inf). t<0 → value 0, neg=1. t>9999 → value 9999, ovf=1. Else value=t.
  - BCD: 14 cycles of shift-add-3 on the 14-bit value.
  - OUT (1 cycle): res_valid=1 with res_ch/res_bcd/flags. Update alarm[ch]. Clear the accumulator. Advance the channel; N_CH-1 wraps to 0. If enable=1 go to REQ, else go to IDLE.
- Result outputs hold their values after the res_valid pulse until the next OUT.
- Latency: res_valid asserts exactly 17 clk edges after the edge that samples the final smp_valid of a channel (1 ACC + 1 SCALE + 14 BCD + 1 OUT).
- smp_valid outside WAIT is ignored. smp_valid in the same cycle the timeout expires is accepted; the valid takes priority.
- enable deassert mid-channel: the current channel completes through OUT, then the block goes to IDLE. enable has no effect inside a channel.
- Timeout result: res_bcd=0, res_err=1, neg/ovf=0, alarm[ch] unchanged, partial accumulation discarded.
- Alarm update (non-error results only): set when value ≥ ALARM_TENTHS; cleared when value < ALARM_TENTHS−HYST_TENTHS; otherwise held. neg → value 0.
- Only one conversion is outstanding at a time; smp_req is never reasserted before smp_valid or timeout.

Test Plan:
1. N_CH=4, default params. Respond to every request on ch0 with 2000 → ch0 result res_bcd=0x0250 (25.0 °C), neg/ovf/err=0, res_valid 17 cycles after the 8th valid. Then smp_ch=1 on the next request.
2. Ch1 samples alternate 2400/2408 → avg 2404, t=300 → res_bcd=0x0300, alarm[1]=1. Next scan at 2300 (t=287, 287≥280) → alarm[1] held at 1. Next scan at 2200 (t=275) → alarm[1]=0.
3. Ch2 samples −800 → res_neg=1, res_bcd=0x0000, alarm[2] unchanged. Bench with SCALE_SHIFT=0 and samples 32767 → res_ovf=1, res_bcd=0x9999.
4. TIMEOUT=50. Withhold smp_valid on ch3 after 3 samples → res_valid with res_err=1, res_bcd=0 exactly 50 cycles after the WAIT entry. Next smp_ch=0 (wrap-around).
5. Drop enable during ch0's 4th sample → ch0 completes with its result, then no smp_req follows. Re-raise enable → smp_req with smp_ch=1.
6. Assert rst for 1 cycle during BCD → all outputs 0 next cycle, smp_ch=0. A stray smp_valid while IDLE produces no result.
